// File: rtl/wb_data_ram_pkg.sv
// Shared constants for the data RAM responder: FSM state encodings and bus widths.
// Optional error response is enabled with the WB_DATA_RAM_ERR_EN macro.
package wb_data_ram_pkg;

    localparam int BUS_W = 32;
    localparam int SEL_W = BUS_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

endpackage

// File: rtl/wb_data_ram_if.sv
// Data-bus bundle between the CPU (master) and the data RAM (slave).
// wb_err_o exists only when WB_DATA_RAM_ERR_EN is defined.
interface wb_data_ram_if;
    import wb_data_ram_pkg::*;

    // Handshake: a request is presented while cyc && stb; the slave answers with
    // a one-cycle ack (or err) pulse, and read data is valid only during that pulse.
    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic             wb_we_i;
    logic [BUS_W-1:0] wb_adr_i;
    logic [SEL_W-1:0] wb_sel_i;
    logic [BUS_W-1:0] wb_dat_i;
    logic [BUS_W-1:0] wb_dat_o;
    logic             wb_ack_o;
`ifdef WB_DATA_RAM_ERR_EN
    logic             wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
`else
    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
`endif

endinterface

// File: rtl/wb_data_ram_bank.sv
// Word-wide storage array: one byte-enabled write port and one registered read port.
module wb_data_ram_bank
    import wb_data_ram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [SEL_W-1:0]      be,
    input  logic [BUS_W-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [BUS_W-1:0]      rdata
);

    logic [BUS_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // be[3] covers bits 31:24 (big-endian MIPS lane order)
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (be[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[rd_idx];
    end

endmodule

// File: rtl/wb_data_ram.sv
// Wishbone data RAM responder with fixed wait states and byte-lane writes.
// Define WB_DATA_RAM_ERR_EN to answer out-of-range addresses with wb_err_o.
module wb_data_ram
    import wb_data_ram_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    wb_data_ram_if.slave     bus,
    output logic [1:0]       state_dbg
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  we_q;
    logic [SEL_W-1:0]      sel_q;
    logic [BUS_W-1:0]      dat_q;
    logic [BUS_W-1:0]      rd_data;
    logic                  req;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [1:0]            term_now;
    logic [1:0]            term_q;
    logic                  unused_adr;

    assign req     = bus.wb_cyc_i && bus.wb_stb_i;
    assign req_idx = bus.wb_adr_i[DEPTH_LOG2+1:2];

`ifdef WB_DATA_RAM_ERR_EN
    logic oor;
    logic oor_q;
    assign oor        = |bus.wb_adr_i[BUS_W-1:DEPTH_LOG2+2];
    assign term_now   = oor   ? ST_ERR : ST_ACK;
    assign term_q     = oor_q ? ST_ERR : ST_ACK;
    assign unused_adr = ^bus.wb_adr_i[1:0];
    assign bus.wb_err_o = (state == ST_ERR);
`else
    // Upper address bits are dropped, so out-of-range requests alias into the array.
    assign term_now   = ST_ACK;
    assign term_q     = ST_ACK;
    assign unused_adr = ^{bus.wb_adr_i[BUS_W-1:DEPTH_LOG2+2], bus.wb_adr_i[1:0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            idx_q <= '0;
            we_q  <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
`ifdef WB_DATA_RAM_ERR_EN
            oor_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        idx_q <= req_idx;
                        we_q  <= bus.wb_we_i;
                        sel_q <= bus.wb_sel_i;
                        dat_q <= bus.wb_dat_i;
`ifdef WB_DATA_RAM_ERR_EN
                        oor_q <= oor;
`endif
                        cnt   <= WAIT_INIT;
                        state <= (WAIT_CYCLES > 0) ? ST_WAIT : term_now;
                    end
                end
                ST_WAIT: begin
                    // Dropping cyc abandons the request without a write or ack.
                    if (!bus.wb_cyc_i) begin
                        state <= ST_IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) state <= term_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read index follows the bus while idle so a zero-wait read lands in the ACK cycle.
    wb_data_ram_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
        .clk    (clk),
        .we     ((state == ST_ACK) && we_q),
        .wr_idx (idx_q),
        .be     (sel_q),
        .wdata  (dat_q),
        .rd_idx ((state == ST_IDLE) ? req_idx : idx_q),
        .rdata  (rd_data)
    );

    assign bus.wb_ack_o = (state == ST_ACK);
    assign bus.wb_dat_o = (state == ST_ACK) ? rd_data : '0;
    assign state_dbg    = state;

endmodule

// File: doc/wb_data_ram.md
# wb_data_ram

Wishbone-style single-port data RAM responder for the OpenMIPS minimal SOPC. It answers the processor's data-bus requests with a fixed number of wait states and supports byte-lane writes in big-endian MIPS lane order. It sits on the responder side of the data bus, beside the instruction ROM, and lets the CPU's stall and handshake logic be exercised under realistic memory latency.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: RAM holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, 2: wait states inserted before ack; legal range 0–15.

Ports (reset is asynchronous and active-low):
- `clk` in 1: single clock; all logic updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wb_cyc_i` in 1: bus cycle active.
- `wb_stb_i` in 1: strobe, request valid.
- `wb_we_i` in 1: 1 = write, 0 = read.
- `wb_adr_i` in 32: byte address.
- `wb_sel_i` in 4: byte-lane enables; sel[3] covers bits 31:24.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data; valid only while ack is high.
- `wb_ack_o` out 1: single-cycle completion pulse.
- `wb_err_o` out 1: error pulse; present only with `WB_DATA_RAM_ERR_EN`.

## Operation
- FSM states: IDLE, WAIT, ACK (plus ERR when the macro is enabled).
- **IDLE:** on a rising edge with cyc && stb, latch adr, we, sel and dat, and load the wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, otherwise ACK.
- **WAIT:** decrement the counter each cycle. Go to ACK when the counter reaches 1 and decrements to 0.
- **ACK:** wb_ack_o = 1 for exactly one cycle. Next state is IDLE unconditionally.
  - Write: latched data is written to each lane whose sel bit is set; other lanes keep their value.
  - Read: wb_dat_o holds the full word at the latched address; sel is ignored for reads.
- **Abort:** if cyc falls in WAIT, return to IDLE next cycle. No write occurs and no ack is issued.
- **Addressing:** word index = adr[DEPTH_LOG2+1:2]; adr[1:0] are ignored.
  - Out-of-range means any of adr[31:DEPTH_LOG2+2] is nonzero.
- **Reset:** wb_ack_o = 0, wb_dat_o = 0, wb_err_o = 0, state IDLE, counter 0. RAM contents are not reset.
  - Reset asserted mid-transaction abandons it; no write occurs.
- Writes take effect on the edge that ends the ACK cycle. A read issued after that edge returns the new data.

## Timing
- Request sampled at edge N; wb_ack_o is high during cycle N+WAIT_CYCLES+1.
- Read data is registered and valid in the same cycle as ack.
- After every ack or err there is at least one IDLE cycle. stb still high in that cycle is sampled at the following edge as a new request.
- Request-to-request throughput is WAIT_CYCLES+2 cycles.
- wb_dat_o returns to 0 in the cycle after ack.
- Inputs other than cyc are ignored outside IDLE.

## Configuration
- `WB_DATA_RAM_ERR_EN` defined:
  - Out-of-range requests take the same latency but pulse wb_err_o instead of wb_ack_o.
  - They perform no write and return wb_dat_o = 0.
- Undefined:
  - The wb_err_o port and the ERR state are absent.
  - Upper address bits are ignored, so out-of-range addresses alias into the RAM and complete normally.

## Structure
- The shared defines file holds the FSM state encodings (2-bit) and the 32-bit bus width constant used by the whole SOPC.
- Sub-module `wb_data_ram_bank` is the storage array: one write port with 4-bit byte enables and one registered read port, parameterised by DEPTH_LOG2.
- The FSM, wait counter and request latches live in the top module.

## Test plan
- **Write then read:** WAIT_CYCLES=2; write 0x12345678 to 0x00000010 with sel=4'hF, then read 0x10 → ack 3 cycles after each request; read returns 0x12345678.
- **Byte-lane write:** over 0x12345678, write 0xAABBCCDD with sel=4'b0101 → read returns 0x12BB56DD.
- **Abort:** deassert cyc during WAIT of a write of 0xFFFFFFFF → no ack; a subsequent read returns the prior value.
- **Back-to-back requests:** stb held high for two reads at 0x0 and 0x4 with WAIT_CYCLES=0 → acks in cycles N+1 and N+3; each returns the correct word.
- **Out-of-range:** access 0x00010000 with DEPTH_LOG2=10.
  - With the macro: wb_err_o pulses, no ack, no write.
  - Without the macro: ack, and the data aliases word 0.
- **Reset mid-write:** drop rst low during WAIT → ack and dat_o are 0 immediately (asynchronous); after release, a read shows the target word unchanged.
